// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage of the 16-bit datapath. Accepts load/store requests from
// execute over a valid/ready handshake. Stores go into a small circular store
// buffer and drain to the single data-memory port in cycles that carry no
// load. A load either reads memory combinationally or forwards from the
// youngest buffered store whose decoded address matches. In both cases the
// result is returned one cycle after acceptance.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake; req_ready comes from registered state only
//   req_we              : 1 = store, 0 = load
//   req_addr/req_wdata  : word address / store data
//   rsp_valid/rsp_rdata : one-cycle load response
//   mem_access_addr     : memory address (load address or drained store address)
//   mem_write_data      : drained store data
//   mem_write_en        : memory write strobe, memory writes on rising clk
//   mem_read            : memory read strobe
//   mem_read_data       : combinational memory read data
//   sb_empty            : store buffer holds no entries
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int SB_DEPTH = 2,
    parameter int RAM_AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    // Store buffer storage and control state
    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Response registers
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // Per-cycle decisions
    logic              accept;
    logic              load_acc;
    logic              push;
    logic              pop;

    // Forwarding
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  fwd_idx;

    assign req_ready = (count_q != CNT_W'(SB_DEPTH));
    assign sb_empty  = (count_q == '0);

    // The handshake is ignored while reset is held, so the memory port stays
    // quiet during reset even if execute keeps a request asserted.
    assign accept   = req_valid && req_ready && !rst;
    assign load_acc = accept && !req_we;
    assign push     = accept && req_we;
    // A load owns the port; otherwise the head entry drains whenever one exists.
    assign pop      = !load_acc && !rst && (count_q != '0);

    // Walk the valid entries from oldest to youngest so the last match wins,
    // which selects the youngest matching store. Only the decoded low address
    // bits are compared, so aliases forward to each other exactly as memory
    // would resolve them.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (sb_addr_q[fwd_idx][RAM_AW-1:0] == req_addr[RAM_AW-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[fwd_idx];
            end
        end
    end

    // Memory port: a load cycle, a drain cycle, or idle with all outputs at zero.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (load_acc) begin
            mem_access_addr = req_addr;
            mem_read        = 1'b1;
        end else if (pop) begin
            mem_access_addr = sb_addr_q[head_q];
            mem_write_data  = sb_data_q[head_q];
            mem_write_en    = 1'b1;
        end
    end

    // Next-state for pointers, count and response
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        rsp_valid_d = load_acc;
        rsp_rdata_d = rsp_rdata_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (load_acc) begin
            rsp_rdata_d = fwd_hit ? fwd_data : mem_read_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // NOTE: entry storage has no reset; an entry only counts once count_q
    // covers it, so clearing the pointers and count is enough to discard it.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_q[tail_q] <= req_addr;
            sb_data_q[tail_q] <= req_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the 16-bit datapath, sitting directly upstream of the data memory: it accepts load/store requests from execute through a valid/ready handshake and buffers stores in a small FIFO. Buffered stores drain to memory when the single memory port is free. Loads either read memory or forward from the youngest matching buffered store, and return data one cycle after acceptance.

## Interface
- `ADDR_W`, 16, request/memory address width
- `DATA_W`, 16, data width
- `SB_DEPTH`, 2, store-buffer entries (power of two, ≥2)
- `RAM_AW`, 3, address bits decoded by the data memory; used for forwarding compare
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in ADDR_W: byte-free word address
- `req_wdata` in DATA_W: store data
- `rsp_valid` out 1: load data valid, one-cycle pulse
- `rsp_rdata` out DATA_W: load result
- `mem_access_addr` out ADDR_W: to memory
- `mem_write_data` out DATA_W: to memory
- `mem_write_en` out 1: to memory, written on rising `clk`
- `mem_read` out 1: to memory
- `mem_read_data` in DATA_W: combinational memory read data
- `sb_empty` out 1: store buffer empty

## Operation
- Store buffer is a circular FIFO with head pointer, tail pointer and count (0..SB_DEPTH). Each entry holds addr and data.
- `req_ready = (count != SB_DEPTH)`. While the buffer is full, loads and stores both stall.
- Accepted store: pushes {addr, wdata} at tail. Produces no response.
- Accepted load (port cycle): drives `mem_access_addr = req_addr`, `mem_read = 1`, `mem_write_en = 0`.
  - Forwarding compares `req_addr[RAM_AW-1:0]` against every valid entry. On a hit, the youngest matching entry's data is selected. On a miss, `mem_read_data` is selected.
  - The selected value is registered into `rsp_rdata` and `rsp_valid` is set for the next cycle.
- Drain cycle: a cycle with no accepted load and `count > 0`.
  - Drives the head entry: `mem_access_addr = head.addr`, `mem_write_data = head.data`, `mem_write_en = 1`, `mem_read = 0`.
  - The head pops at that rising edge.
- Idle cycle (no load, empty buffer): all memory outputs are 0.
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo SB_DEPTH.
- A store accepted in cycle N cannot drain before cycle N+1, because draining reads only registered entries.
- Load priority starves drain only while the buffer is not full. A full buffer drops `req_ready`, which forces a drain cycle.
- Reset, asserted asynchronously at any time including mid-drain:
  - count, head and tail go to 0; buffered stores are discarded.
  - `rsp_valid = 0`, `rsp_rdata = 0`, `req_ready = 1`, `sb_empty = 1`.
  - `mem_write_en = 0`, `mem_read = 0`, `mem_access_addr = 0`, `mem_write_data = 0`.

## Timing
- Load latency: exactly 1 cycle, acceptance edge to `rsp_valid` high. The pulse lasts one cycle unless the next cycle also accepts a load, so back-to-back loads give back-to-back responses.
- Memory read is combinational in the accept cycle; result captured at the same edge.
- Store visibility to loads is immediate, via forwarding, from the cycle after acceptance. Visibility in memory follows at the drain edge.
- `req_ready` depends only on registered count (no combinational path from `req_valid`).
- Memory-port outputs are combinational from `req_*` and registered head state.
- Address aliasing: entries whose addresses differ only above bit RAM_AW-1 forward to each other, matching memory decode.

## Test plan
- Reset: assert `rst` mid-stream with 2 stores buffered, then release. Required: `sb_empty = 1`, `req_ready = 1`, `rsp_valid = 0`, and no `mem_write_en` pulse for the discarded stores.
- Store forward: store 0xBEEF @ 0x0005, then load 0x0005 in the next cycle. Required: no drain has occurred yet, and `rsp_rdata = 0xBEEF` one cycle later.
- Drain then load: store 0x1234 @ 0x0002, 2 idle cycles, then load 0x0002. Required:
  - `mem_write_en` is high for exactly 1 cycle with addr 0x0002.
  - The load drives `mem_read = 1` and returns 0x1234 from memory.
- Full stall: with loads held continuously, accept 2 stores. Required: `req_ready = 0` until the next drain cycle, then 1.
- Youngest match with aliasing: store 0x1111 @ 0x0003, then 0x2222 @ 0x000B (same low 3 bits), then load 0x0003. Required: `rsp_rdata = 0x2222`.
- Back-to-back loads: loads 0x0000 and 0x0001 on consecutive cycles. Required: two consecutive `rsp_valid` cycles carrying memory words 0 and 1, with no writes during them.
